jtbubl_snd_comm: RTL and testbench
==================================

JTBUBL_SND_COMM -- requirements
Module: jtbubl_snd_comm

Interface
REQ-001 Parameter RST_LEN, default 16: minimum cycles the sound CPU reset is held after a reset request.
REQ-002 Parameter OVR_W, default 4: width of the command-overrun counter.
REQ-003 clk  in  1  system clock; the block uses this single clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 main_cs  in  1  main-CPU select for this block's 4-register window.
REQ-006 main_addr  in  2  register select.
REQ-007 main_wr  in  1  one-cycle write strobe, qualified by main_cs.
REQ-008 main_rd  in  1  one-cycle read strobe, qualified by main_cs.
REQ-009 main_dout  in  8  main-CPU write data.
REQ-010 main_din  out  8  registered read data to the main CPU.
REQ-011 snd_latch  out  8  command byte to the sound CPU.
REQ-012 snd_stb  out  1  one-cycle command strobe to the sound CPU.
REQ-013 snd_flag  in  1  sound-side command flag; low means a command is unread.
REQ-014 main_latch  in  8  reply byte from the sound CPU.
REQ-015 main_stb  in  1  reply strobe from the sound CPU; may stay high several cycles.
REQ-016 main_flag  out  1  high while an unread reply is pending.
REQ-017 rstn  out  1  sound-subsystem reset, active-low.

Function
REQ-018 A write to addr 0 shall load snd_latch with main_dout and pulse snd_stb high for exactly the next cycle.
REQ-019 A write to addr 0 while snd_flag is low shall increment the overrun counter, saturating at all-ones; the command is still sent.
REQ-020 A rising edge of main_stb (registered edge detect) shall capture main_latch into the reply register and set main_flag.
REQ-021 A rising edge of main_stb while main_flag is already set shall overwrite the reply and set the sticky reply-lost bit.
REQ-022 A read of addr 0 shall return the reply register and clear main_flag.
REQ-023 A read of addr 0 in the same cycle as a main_stb rising edge shall return the old reply and leave main_flag set: set wins over clear.
REQ-024 A read of addr 1 shall return the status byte {overrun[3:0], 1'b0, reply_lost, ~snd_flag, main_flag}. For OVR_W≠4, overrun is truncated or zero-extended to 4 bits.
REQ-025 Reads of addr 2 and addr 3 shall return 8'hFF.
REQ-026 main_din shall update on the clock edge at the end of the main_rd cycle, giving 1-cycle latency, and shall hold its value otherwise.
REQ-027 A write to addr 2 shall set reset_req to main_dout[0].
REQ-028 A 0→1 transition of reset_req shall load the hold counter with RST_LEN.
REQ-029 The hold counter shall decrement each cycle while nonzero.
REQ-030 rstn shall be low while reset_req=1 or the hold counter ≠ 0, and high otherwise.
REQ-031 While rstn is low, main_stb edges shall be ignored and snd_stb shall be suppressed; writes to addr 0 still update snd_latch.
REQ-032 A write to addr 3 shall clear the overrun counter and reply_lost.
REQ-033 When an addr-3 clear and an overrun increment occur in the same cycle, the clear shall win.
REQ-034 Strobes without main_cs shall have no effect.

Reset
REQ-035 On rst, the following shall be zero: snd_latch, snd_stb, main_flag, reply register, reply_lost, overrun counter, main_din and the main_stb edge register.
REQ-036 On rst, reset_req shall be set to 1 and the hold counter loaded with RST_LEN, so rstn is low out of reset.
REQ-037 Asserting rst mid-operation shall abort any pending snd_stb pulse and reload the reset hold, regardless of the current counter value.

Structure
REQ-038 Register addresses (CMD=0, STAT=1, CTRL=2, CLR=3) and status bit positions shall live in the shared jtbubl package.
REQ-039 The block shall be flat, except for one optional sub-module jtbubl_edge (registered rising-edge detector), which may be reused for main_stb.

Verification
REQ-040 After rst, hold cycle count: rstn stays low indefinitely with reset_req=1. Write CTRL=0 → rstn rises exactly RST_LEN cycles after the counter load, i.e. immediately since the count has already expired; repeat CTRL=1, then CTRL=0 → rstn low ≥16 cycles.
REQ-041 With snd_flag=1, write CMD=8'h5A → snd_latch=5A, and snd_stb is high exactly one cycle; the overrun counter stays 0.
REQ-042 With snd_flag=0, write CMD three times, then read STAT → 8'h32; write CLR, then read STAT → 8'h02.
REQ-043 Pulse main_stb for 3 cycles with main_latch=8'hC3 → main_flag=1; read CMD → main_din=C3 next cycle and main_flag=0.
REQ-044 Two main_stb edges (8'h11, then 8'h22) without a read → STAT bit2 (reply_lost)=1 and CMD reads 22; a main_stb edge coincident with a CMD read → main_flag remains 1.
REQ-045 With rstn low, main_stb edge and CMD write → main_flag stays 0 and no snd_stb pulse occurs, while snd_latch updates.

Source files
------------

// File: rtl/jtbubl_pkg.sv
// Shared definitions for the Bubble Bobble sound-communication block:
// register map of the main-CPU window and status-byte bit positions.
package jtbubl_pkg;

    typedef enum logic [1:0] {
        REG_CMD  = 2'd0,
        REG_STAT = 2'd1,
        REG_CTRL = 2'd2,
        REG_CLR  = 2'd3
    } reg_addr_e;

    localparam int unsigned ST_MAIN_FLAG  = 0;
    localparam int unsigned ST_SND_PEND   = 1;
    localparam int unsigned ST_REPLY_LOST = 2;
    localparam int unsigned ST_OVR_LSB    = 4;

    localparam logic [7:0] RD_UNUSED = 8'hFF;

endpackage

// File: rtl/jtbubl_edge.sv
// Registered rising-edge detector.
module jtbubl_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    // Next value of the history register is simply the current input
    always_comb begin
        prev_d = din;
    end

    // Keep one cycle of input history
    always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= prev_d;
    end

    assign rise = din & ~prev_q;

endmodule

// File: rtl/jtbubl_snd_comm.sv
// Main-CPU <-> sound-CPU mailbox: command latch, reply latch with flags,
// overrun/lost tracking and a stretched sound-subsystem reset.
module jtbubl_snd_comm
    import jtbubl_pkg::*;
#(
    parameter int unsigned RST_LEN = 16,
    parameter int unsigned OVR_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       main_cs,
    input  logic [1:0] main_addr,
    input  logic       main_wr,
    input  logic       main_rd,
    input  logic [7:0] main_dout,
    output logic [7:0] main_din,
    output logic [7:0] snd_latch,
    output logic       snd_stb,
    input  logic       snd_flag,
    input  logic [7:0] main_latch,
    input  logic       main_stb,
    output logic       main_flag,
    output logic       rstn
);

    localparam int unsigned HW = (RST_LEN < 1) ? 1 : $clog2(RST_LEN + 1);

    logic [7:0]    snd_latch_q,  snd_latch_d;
    logic          snd_stb_q,    snd_stb_d;
    logic          main_flag_q,  main_flag_d;
    logic [7:0]    reply_q,      reply_d;
    logic          reply_lost_q, reply_lost_d;
    logic [OVR_W-1:0] ovr_q,     ovr_d;
    logic [7:0]    main_din_q,   main_din_d;
    logic          reset_req_q,  reset_req_d;
    logic [HW-1:0] hold_q,       hold_d;

    reg_addr_e  addr;
    logic       cmd_wr, ctrl_wr, clr_wr, rd_en;
    logic       stb_rise, reply_set, rstn_int;
    logic [3:0] ovr4;
    logic [7:0] status;

    jtbubl_edge u_stb_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (main_stb),
        .rise (stb_rise)
    );

    generate
        if (OVR_W >= 4) begin : g_ovr_trunc
            assign ovr4 = ovr_q[3:0];
        end else begin : g_ovr_ext
            assign ovr4 = {{(4 - OVR_W){1'b0}}, ovr_q};
        end
    endgenerate

    // Decode bus strobes, build the status byte and compute next state
    always_comb begin
        addr      = reg_addr_e'(main_addr);
        cmd_wr    = main_cs & main_wr & (addr == REG_CMD);
        ctrl_wr   = main_cs & main_wr & (addr == REG_CTRL);
        clr_wr    = main_cs & main_wr & (addr == REG_CLR);
        rd_en     = main_cs & main_rd;
        rstn_int  = ~(reset_req_q | (hold_q != '0));
        reply_set = stb_rise & rstn_int;

        status                = '0;
        status[ST_OVR_LSB +: 4] = ovr4;
        status[ST_REPLY_LOST] = reply_lost_q;
        status[ST_SND_PEND]   = ~snd_flag;
        status[ST_MAIN_FLAG]  = main_flag_q;

        snd_latch_d  = cmd_wr ? main_dout : snd_latch_q;
        snd_stb_d    = cmd_wr & rstn_int;

        ovr_d = ovr_q;
        if (clr_wr)
            ovr_d = '0;
        else if (cmd_wr && !snd_flag && (ovr_q != '1))
            ovr_d = ovr_q + OVR_W'(1);

        // A reply arriving in the same cycle as a CMD read keeps the flag set
        reply_d      = reply_set ? main_latch : reply_q;
        reply_lost_d = clr_wr ? 1'b0 : (reply_lost_q | (reply_set & main_flag_q));
        main_flag_d  = main_flag_q;
        if (reply_set)
            main_flag_d = 1'b1;
        else if (rd_en && addr == REG_CMD)
            main_flag_d = 1'b0;

        main_din_d = main_din_q;
        if (rd_en) begin
            unique case (addr)
                REG_CMD:  main_din_d = reply_q;
                REG_STAT: main_din_d = status;
                default:  main_din_d = RD_UNUSED;
            endcase
        end

        reset_req_d = ctrl_wr ? main_dout[0] : reset_req_q;
        hold_d      = hold_q;
        if (ctrl_wr && main_dout[0] && !reset_req_q)
            hold_d = HW'(RST_LEN);
        else if (hold_q != '0)
            hold_d = hold_q - HW'(1);
    end

    // State registers; reset requests a fresh sound-CPU reset hold
    always_ff @(posedge clk) begin
        if (rst) begin
            snd_latch_q  <= '0;
            snd_stb_q    <= 1'b0;
            main_flag_q  <= 1'b0;
            reply_q      <= '0;
            reply_lost_q <= 1'b0;
            ovr_q        <= '0;
            main_din_q   <= '0;
            reset_req_q  <= 1'b1;
            hold_q       <= HW'(RST_LEN);
        end else begin
            snd_latch_q  <= snd_latch_d;
            snd_stb_q    <= snd_stb_d;
            main_flag_q  <= main_flag_d;
            reply_q      <= reply_d;
            reply_lost_q <= reply_lost_d;
            ovr_q        <= ovr_d;
            main_din_q   <= main_din_d;
            reset_req_q  <= reset_req_d;
            hold_q       <= hold_d;
        end
    end

    assign main_din  = main_din_q;
    assign snd_latch = snd_latch_q;
    assign snd_stb   = snd_stb_q;
    assign main_flag = main_flag_q;
    assign rstn      = rstn_int;

endmodule

// File: tb/tb_jtbubl_snd_comm.sv
// Scoreboard bench for jtbubl_snd_comm: expected read data and command
// pulses are queued by the stimulus and consumed by independent monitors.
module tb_jtbubl_snd_comm;

    logic       clk = 1'b0;
    logic       rst;
    logic       main_cs, main_wr, main_rd, main_stb, snd_flag;
    logic [1:0] main_addr;
    logic [7:0] main_dout, main_latch;
    logic [7:0] main_din, snd_latch;
    logic       snd_stb, main_flag, rstn;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0] rd_q[$];
    logic [7:0] snd_q[$];

    localparam logic [1:0] A_CMD = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2, A_CLR = 2'd3;

    jtbubl_snd_comm #(.RST_LEN(16), .OVR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .main_cs    (main_cs),
        .main_addr  (main_addr),
        .main_wr    (main_wr),
        .main_rd    (main_rd),
        .main_dout  (main_dout),
        .main_din   (main_din),
        .snd_latch  (snd_latch),
        .snd_stb    (snd_stb),
        .snd_flag   (snd_flag),
        .main_latch (main_latch),
        .main_stb   (main_stb),
        .main_flag  (main_flag),
        .rstn       (rstn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        main_cs = 1'b1; main_wr = 1'b1; main_addr = a; main_dout = d;
        @(posedge clk); #1;
        main_cs = 1'b0; main_wr = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        main_cs = 1'b1; main_rd = 1'b1; main_addr = a;
        @(posedge clk); #1;
        main_cs = 1'b0; main_rd = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] d);
        snd_q.push_back(d);
        wr(A_CMD, d);
    endtask

    task automatic stb_pulse(input logic [7:0] d, input int unsigned len);
        main_latch = d; main_stb = 1'b1;
        repeat (len) @(posedge clk);
        #1 main_stb = 1'b0;
        @(posedge clk); #1;
    endtask

    // Read-data monitor: main_din is due one edge after each qualified read
    always @(posedge clk) begin
        if (main_cs && main_rd) begin
            @(negedge clk);
            if (rd_q.size() == 0) check("rd_unexpected", main_din, 8'hxx);
            else                  check("rd_data", main_din, rd_q.pop_front());
        end
    end

    // Command-strobe monitor: every high cycle of snd_stb must match a queued command
    always @(negedge clk) begin
        if (snd_stb === 1'b1) begin
            if (snd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL snd_stb_unexpected: got pulse with latch %h expected none", snd_latch);
            end else begin
                check("snd_latch_at_stb", snd_latch, snd_q.pop_front());
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned lowcnt;
        rst = 1'b1; main_cs = 1'b0; main_wr = 1'b0; main_rd = 1'b0;
        main_addr = '0; main_dout = '0; main_latch = '0; main_stb = 1'b0; snd_flag = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_snd_latch", snd_latch, 8'h00);
        check("rst_snd_stb", {7'd0, snd_stb}, 8'h00);
        check("rst_main_flag", {7'd0, main_flag}, 8'h00);
        check("rst_main_din", main_din, 8'h00);
        check("rst_rstn", {7'd0, rstn}, 8'h00);
        @(posedge clk); #1 rst = 1'b0;

        // Reset hold: reset_req keeps rstn low until CTRL=0
        repeat (40) @(negedge clk);
        check("hold_req_rstn", {7'd0, rstn}, 8'h00);
        wr(A_CTRL, 8'h00);
        @(negedge clk);
        check("ctrl0_rstn", {7'd0, rstn}, 8'h01);
        wr(A_CTRL, 8'h01);
        @(negedge clk);
        lowcnt = rstn ? 0 : 1;
        wr(A_CTRL, 8'h00);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rstn) break;
            lowcnt++;
        end
        check("hold_len", 8'(lowcnt), 8'd16);

        // Single command, no overrun
        cmd(8'h5A);
        @(negedge clk);
        check("cmd_latch", snd_latch, 8'h5A);
        rd(A_STAT, 8'h00);

        // Overrun counting and clear
        snd_flag = 1'b0;
        cmd(8'h01); cmd(8'h02); cmd(8'h03);
        rd(A_STAT, 8'h32);
        wr(A_CLR, 8'h00);
        rd(A_STAT, 8'h02);
        snd_flag = 1'b1;

        // Reply capture with a multi-cycle strobe
        stb_pulse(8'hC3, 3);
        @(negedge clk);
        check("reply_flag_set", {7'd0, main_flag}, 8'h01);
        rd(A_CMD, 8'hC3);
        @(negedge clk);
        check("reply_flag_clr", {7'd0, main_flag}, 8'h00);

        // Lost reply, then edge coincident with a CMD read
        stb_pulse(8'h11, 1);
        stb_pulse(8'h22, 1);
        rd(A_STAT, 8'h05);
        rd(A_CMD, 8'h22);
        main_latch = 8'h33; main_stb = 1'b1;
        rd(A_CMD, 8'h22);
        main_stb = 1'b0;
        @(negedge clk);
        check("set_wins_flag", {7'd0, main_flag}, 8'h01);
        rd(A_CMD, 8'h33);

        // Overrun saturation, sticky lost bit, clear
        snd_flag = 1'b0;
        for (int i = 0; i < 17; i++) cmd(8'(i));
        rd(A_STAT, 8'hF6);
        wr(A_CLR, 8'h00);
        rd(A_STAT, 8'h02);
        snd_flag = 1'b1;
        rd(A_CTRL, 8'hFF);
        rd(A_CLR, 8'hFF);

        // Strobes without chip select do nothing
        main_wr = 1'b1; main_addr = A_CMD; main_dout = 8'hEE;
        @(posedge clk); #1 main_wr = 1'b0;
        main_rd = 1'b1; main_addr = A_STAT;
        @(posedge clk); #1 main_rd = 1'b0;
        @(negedge clk);
        check("nocs_latch", snd_latch, 8'h10);
        check("nocs_din", main_din, 8'hFF);

        // Sound subsystem held in reset: replies ignored, strobe suppressed
        wr(A_CTRL, 8'h01);
        stb_pulse(8'h77, 1);
        wr(A_CMD, 8'h9C);
        @(negedge clk);
        check("rsthold_flag", {7'd0, main_flag}, 8'h00);
        check("rsthold_latch", snd_latch, 8'h9C);
        wr(A_CTRL, 8'h00);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rstn) break;
        end
        check("rsthold_release", {7'd0, rstn}, 8'h01);
        rd(A_CMD, 8'h33);

        // Reset mid-operation aborts a pending command strobe
        @(posedge clk); #1;
        rst = 1'b1; main_cs = 1'b1; main_wr = 1'b1; main_addr = A_CMD; main_dout = 8'hAA;
        @(posedge clk); #1;
        main_cs = 1'b0; main_wr = 1'b0;
        @(negedge clk);
        check("midrst_stb", {7'd0, snd_stb}, 8'h00);
        check("midrst_latch", snd_latch, 8'h00);
        check("midrst_rstn", {7'd0, rstn}, 8'h00);
        rst = 1'b0;

        repeat (4) @(negedge clk);
        check("snd_queue_empty", 8'(snd_q.size()), 8'd0);
        check("rd_queue_empty", 8'(rd_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
